// File: rtl/ct_fadd_pkg.sv
// Shared FADD normalization constants and leading-one detection helper.
package ct_fadd_pkg;

  localparam int unsigned MANT_W  = 54;
  localparam int unsigned SHAMT_W = 6;

  typedef struct packed {
    logic [MANT_W-1:0]  onehot;
    logic [SHAMT_W-1:0] shamt;
    logic               zero;
  } lod_t;

  // Priority encoder: the highest set bit wins because later iterations override.
  function automatic lod_t lod(input logic [MANT_W-1:0] d);
    lod_t r;
    r.onehot = '0;
    r.shamt  = '0;
    r.zero   = (d == '0);
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (d[i]) begin
        r.onehot    = '0;
        r.onehot[i] = 1'b1;
        r.shamt     = SHAMT_W'(MANT_W - 1 - i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ct_fadd_onehot_sel_d.sv
// One-hot selected left shifter: moves the bit flagged in onehot up to the MSB.
module ct_fadd_onehot_sel_d
  import ct_fadd_pkg::*;
(
  input  logic [MANT_W-1:0] data_in,
  input  logic [MANT_W-1:0] onehot,
  output logic [MANT_W-1:0] result
);

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (onehot[i]) result = result | (data_in << (MANT_W - 1 - i));
    end
  end

endmodule

// File: rtl/ct_fadd_norm_ctrl.sv
// Round-robin scheduler for the shared normalization shifter, two-stage valid/ready pipe.
module ct_fadd_norm_ctrl
  import ct_fadd_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                flush,
  input  logic                req0_vld,
  input  logic [MANT_W-1:0]   req0_data,
  input  logic [TAG_W-1:0]    req0_tag,
  output logic                req0_rdy,
  input  logic                req1_vld,
  input  logic [MANT_W-1:0]   req1_data,
  input  logic [TAG_W-1:0]    req1_tag,
  output logic                req1_rdy,
  output logic                norm_vld,
  output logic [MANT_W-1:0]   norm_data,
  output logic [SHAMT_W-1:0]  norm_shamt,
  output logic                norm_zero,
  output logic                norm_src,
  output logic [TAG_W-1:0]    norm_tag,
  input  logic                norm_rdy
);

  logic                rr_q, rr_d;
  logic                s1_vld_q, s1_vld_d;
  logic [MANT_W-1:0]   s1_data_q, s1_data_d;
  logic [MANT_W-1:0]   s1_onehot_q, s1_onehot_d;
  logic [SHAMT_W-1:0]  s1_shamt_q, s1_shamt_d;
  logic                s1_zero_q, s1_zero_d;
  logic                s1_src_q, s1_src_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
  logic                s2_vld_q, s2_vld_d;
  logic [MANT_W-1:0]   s2_data_q, s2_data_d;
  logic [SHAMT_W-1:0]  s2_shamt_q, s2_shamt_d;
  logic                s2_zero_q, s2_zero_d;
  logic                s2_src_q, s2_src_d;
  logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;

  logic                gnt0, gnt1, s2_adv, s1_free, accept;
  logic [MANT_W-1:0]   acc_data;
  lod_t                acc_lod;
  logic [MANT_W-1:0]   sel_result;

  ct_fadd_onehot_sel_d u_sel (
    .data_in (s1_data_q),
    .onehot  (s1_onehot_q),
    .result  (sel_result)
  );

  always_comb begin
    gnt0     = req0_vld & (~req1_vld | ~rr_q);
    gnt1     = req1_vld & (~req0_vld | rr_q);
    s2_adv   = s1_vld_q & (~s2_vld_q | norm_rdy);
    s1_free  = ~s1_vld_q | s2_adv;
    req0_rdy = gnt0 & s1_free & ~flush & ~cpurst;
    req1_rdy = gnt1 & s1_free & ~flush & ~cpurst;
    accept   = req0_rdy | req1_rdy;
    acc_data = req1_rdy ? req1_data : req0_data;
    acc_lod  = lod(acc_data);
  end

  always_comb begin
    rr_d        = rr_q;
    s1_vld_d    = s1_vld_q;
    s1_data_d   = s1_data_q;
    s1_onehot_d = s1_onehot_q;
    s1_shamt_d  = s1_shamt_q;
    s1_zero_d   = s1_zero_q;
    s1_src_d    = s1_src_q;
    s1_tag_d    = s1_tag_q;
    s2_vld_d    = s2_vld_q;
    s2_data_d   = s2_data_q;
    s2_shamt_d  = s2_shamt_q;
    s2_zero_d   = s2_zero_q;
    s2_src_d    = s2_src_q;
    s2_tag_d    = s2_tag_q;
    // flush overrides both the accept and the advance path
    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_vld_d   = 1'b1;
        s2_data_d  = sel_result;
        s2_shamt_d = s1_shamt_q;
        s2_zero_d  = s1_zero_q;
        s2_src_d   = s1_src_q;
        s2_tag_d   = s1_tag_q;
      end else if (norm_rdy) begin
        s2_vld_d = 1'b0;
      end
      if (accept) begin
        s1_vld_d    = 1'b1;
        s1_data_d   = acc_data;
        s1_onehot_d = acc_lod.onehot;
        s1_shamt_d  = acc_lod.shamt;
        s1_zero_d   = acc_lod.zero;
        s1_src_d    = req1_rdy;
        s1_tag_d    = req1_rdy ? req1_tag : req0_tag;
        if (req0_vld & req1_vld) rr_d = ~rr_q;
      end else if (s2_adv) begin
        s1_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rr_q        <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_onehot_q <= '0;
      s1_shamt_q  <= '0;
      s1_zero_q   <= 1'b0;
      s1_src_q    <= 1'b0;
      s1_tag_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_data_q   <= '0;
      s2_shamt_q  <= '0;
      s2_zero_q   <= 1'b0;
      s2_src_q    <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      rr_q        <= rr_d;
      s1_vld_q    <= s1_vld_d;
      s1_data_q   <= s1_data_d;
      s1_onehot_q <= s1_onehot_d;
      s1_shamt_q  <= s1_shamt_d;
      s1_zero_q   <= s1_zero_d;
      s1_src_q    <= s1_src_d;
      s1_tag_q    <= s1_tag_d;
      s2_vld_q    <= s2_vld_d;
      s2_data_q   <= s2_data_d;
      s2_shamt_q  <= s2_shamt_d;
      s2_zero_q   <= s2_zero_d;
      s2_src_q    <= s2_src_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign norm_vld   = s2_vld_q;
  assign norm_data  = s2_data_q;
  assign norm_shamt = s2_shamt_q;
  assign norm_zero  = s2_zero_q;
  assign norm_src   = s2_src_q;
  assign norm_tag   = s2_tag_q;

endmodule

// File: tb/tb_ct_fadd_norm_ctrl.sv
// Bench for ct_fadd_norm_ctrl: directed literal checks plus a random run against an item-level model.
module tb_ct_fadd_norm_ctrl;

  logic        clk = 1'b0;
  logic        cpurst, flush;
  logic        req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic [53:0] req0_data, req1_data;
  logic [7:0]  req0_tag, req1_tag;
  logic        norm_vld, norm_zero, norm_src, norm_rdy;
  logic [53:0] norm_data;
  logic [5:0]  norm_shamt;
  logic [7:0]  norm_tag;

  always #5 clk = ~clk;

  ct_fadd_norm_ctrl #(.TAG_W(8)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .flush          (flush),
    .req0_vld       (req0_vld),
    .req0_data      (req0_data),
    .req0_tag       (req0_tag),
    .req0_rdy       (req0_rdy),
    .req1_vld       (req1_vld),
    .req1_data      (req1_data),
    .req1_tag       (req1_tag),
    .req1_rdy       (req1_rdy),
    .norm_vld       (norm_vld),
    .norm_data      (norm_data),
    .norm_shamt     (norm_shamt),
    .norm_zero      (norm_zero),
    .norm_src       (norm_src),
    .norm_tag       (norm_tag),
    .norm_rdy       (norm_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [53:0] data;
    logic [5:0]  shamt;
    logic        zero;
    logic        src;
    logic [7:0]  tag;
  } item_t;

  function automatic item_t mk(input logic [53:0] d, input logic s, input logic [7:0] t);
    item_t it;
    logic [53:0] v = d;
    int n = 0;
    it.src  = s;
    it.tag  = t;
    it.zero = (d == 54'd0);
    if (d == 54'd0) begin
      it.data  = '0;
      it.shamt = '0;
    end else begin
      while (!v[53]) begin
        v = v << 1;
        n++;
      end
      it.data  = v;
      it.shamt = 6'(n);
    end
    return it;
  endfunction

  logic  m_rr, m_s1_v, m_s2_v, m_clean, started = 1'b0;
  item_t m_s1, m_s2;

  function automatic logic [1:0] exp_rdy();
    logic g0, g1, room;
    g0   = req0_vld && (!req1_vld || !m_rr);
    g1   = req1_vld && (!req0_vld || m_rr);
    room = !m_s1_v || !m_s2_v || norm_rdy;
    if (cpurst || flush || !room) return 2'b00;
    return {g1, g0};
  endfunction

  initial begin
    forever begin
      logic [1:0] e;
      logic       adv;
      @(posedge clk);
      if (cpurst) begin
        m_rr = 0; m_s1_v = 0; m_s2_v = 0; m_clean = 1;
        m_s1 = '0; m_s2 = '0;
        started = 1'b1;
      end else if (started) begin
        e   = exp_rdy();
        adv = m_s1_v && (!m_s2_v || norm_rdy);
        if (flush) begin
          m_s1_v = 0; m_s2_v = 0;
        end else begin
          if (adv) begin
            m_s2 = m_s1; m_s2_v = 1; m_clean = 0;
          end else if (norm_rdy) m_s2_v = 0;
          if (e != 2'b00) begin
            m_s1   = e[1] ? mk(req1_data, 1'b1, req1_tag) : mk(req0_data, 1'b0, req0_tag);
            m_s1_v = 1;
            if (req0_vld && req1_vld) m_rr = !m_rr;
          end else if (adv) m_s1_v = 0;
        end
      end
    end
  end

  // Compare process: every cycle once the model has seen reset.
  initial begin
    forever begin
      logic [1:0] e;
      @(negedge clk);
      #2;
      if (started) begin
        e = exp_rdy();
        chk("m_req0_rdy", 64'(req0_rdy), 64'(e[0]));
        chk("m_req1_rdy", 64'(req1_rdy), 64'(e[1]));
        chk("m_norm_vld", 64'(norm_vld), 64'(m_s2_v));
        if (m_s2_v || m_clean) begin
          chk("m_norm_data",  64'(norm_data),  64'(m_s2.data));
          chk("m_norm_shamt", 64'(norm_shamt), 64'(m_s2.shamt));
          chk("m_norm_zero",  64'(norm_zero),  64'(m_s2.zero));
          chk("m_norm_src",   64'(norm_src),   64'(m_s2.src));
          chk("m_norm_tag",   64'(norm_tag),   64'(m_s2.tag));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    req0_vld = 0; req1_vld = 0; flush = 0; cpurst = 0;
  endtask

  initial begin
    logic [63:0] r;
    cpurst = 1; flush = 0; norm_rdy = 1;
    req0_vld = 0; req1_vld = 0; req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0;
    repeat (2) @(negedge clk);

    // reset state + single op
    idle();
    req0_vld = 1; req0_data = 54'h00_0000_0000_0001; req0_tag = 8'h5A;
    #1;
    chk("rst_vld", 64'(norm_vld), 0);
    chk("rst_data", 64'(norm_data), 0);
    chk("rst_tag", 64'(norm_tag), 0);
    chk("single_rdy", 64'(req0_rdy), 1);
    @(negedge clk);
    idle();
    #1 chk("single_lat1_vld", 64'(norm_vld), 0);
    @(negedge clk);
    req1_vld = 1; req1_data = '0; req1_tag = 8'h33;
    #1;
    chk("single_vld", 64'(norm_vld), 1);
    chk("single_data", 64'(norm_data), 64'h20_0000_0000_0000);
    chk("single_shamt", 64'(norm_shamt), 53);
    chk("single_zero", 64'(norm_zero), 0);
    chk("single_src", 64'(norm_src), 0);
    chk("single_tag", 64'(norm_tag), 8'h5A);
    chk("zero_rdy", 64'(req1_rdy), 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    chk("zero_vld", 64'(norm_vld), 1);
    chk("zero_data", 64'(norm_data), 0);
    chk("zero_flag", 64'(norm_zero), 1);
    chk("zero_shamt", 64'(norm_shamt), 0);
    chk("zero_src", 64'(norm_src), 1);

    // contention: alternate grants starting at req0
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) begin
        req0_vld = 1; req0_data = 54'h1 << (k + 3); req0_tag = 8'hA0 + 8'(k);
        req1_vld = 1; req1_data = 54'h1 << (k + 9); req1_tag = 8'hB0 + 8'(k);
      end
      #1;
      if (k < 4) begin
        chk("cont_rdy0", 64'(req0_rdy), 64'(k % 2 == 0));
        chk("cont_rdy1", 64'(req1_rdy), 64'(k % 2 == 1));
      end
      if (k >= 2) begin
        chk("cont_vld", 64'(norm_vld), 1);
        chk("cont_src", 64'(norm_src), 64'((k - 2) % 2));
        chk("cont_tag", 64'(norm_tag), ((k - 2) % 2 == 1) ? 64'(8'hB0 + 8'(k - 2)) : 64'(8'hA0 + 8'(k - 2)));
      end
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);

    // backpressure fill, then flush with a pending request
    norm_rdy = 0;
    for (int k = 0; k < 7; k++) begin
      idle();
      req0_vld = (k <= 4); req0_data = 54'h3 << k; req0_tag = 8'hC0 + 8'((k > 2) ? 2 : k);
      flush = (k == 3);
      norm_rdy = (k >= 4);
      #1;
      case (k)
        0, 1: chk("bp_rdy_free", 64'(req0_rdy), 1);
        2: chk("bp_rdy_full", 64'(req0_rdy), 0);
        3: begin
          chk("flush_rdy", 64'(req0_rdy), 0);
          chk("bp_hold_tag", 64'(norm_tag), 8'hC0);
        end
        4: begin
          chk("flush_vld", 64'(norm_vld), 0);
          chk("flush_after_rdy", 64'(req0_rdy), 1);
        end
        6: begin
          chk("flush_res_vld", 64'(norm_vld), 1);
          chk("flush_res_tag", 64'(norm_tag), 8'hC2);
        end
        default: ;
      endcase
      if (k == 4) begin
        @(negedge clk);
        idle();
        req0_vld = 0;
        k++;
      end else if (k == 5) begin
      end
      @(negedge clk);
    end
    idle();
    norm_rdy = 1;
    @(negedge clk);

    // reset mid-stream; rr must come back to req0
    norm_rdy = 0;
    req0_vld = 1; req1_vld = 1; req0_data = 54'h55; req1_data = 54'h77; req0_tag = 8'hD0; req1_tag = 8'hE0;
    #1 chk("pre_rst_rdy0", 64'(req0_rdy), 1);
    @(negedge clk);
    req0_vld = 0; req1_tag = 8'hE1;
    #1 chk("pre_rst_rdy1", 64'(req1_rdy), 1);
    @(negedge clk);
    cpurst = 1; req0_vld = 1; req1_vld = 1;
    #1 chk("rst_rdy1_low", 64'(req1_rdy), 0);
    @(negedge clk);
    cpurst = 0; norm_rdy = 1;
    #1;
    chk("mid_rst_vld", 64'(norm_vld), 0);
    chk("mid_rst_data", 64'(norm_data), 0);
    chk("mid_rst_tag", 64'(norm_tag), 0);
    chk("mid_rst_shamt", 64'(norm_shamt), 0);
    chk("mid_rst_rr0", 64'(req0_rdy), 1);
    chk("mid_rst_rr1", 64'(req1_rdy), 0);
    @(negedge clk);

    // random run against the model
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom, $urandom};
      req0_data = r[53:0] >> $urandom_range(0, 54);
      r = {$urandom, $urandom};
      req1_data = r[53:0] >> $urandom_range(0, 54);
      req0_tag = 8'($urandom);
      req1_tag = 8'($urandom);
      req0_vld = ($urandom_range(0, 99) < 60);
      req1_vld = ($urandom_range(0, 99) < 60);
      norm_rdy = ($urandom_range(0, 99) < 75);
      flush    = ($urandom_range(0, 99) < 3);
      cpurst   = ($urandom_range(0, 199) < 1);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ct_fadd_norm_ctrl.md
# ct_fadd_norm_ctrl

Two-requester scheduler for the shared FADD normalization shifter. It arbitrates round-robin between two pipe requesters and performs leading-one detection to build the 54-bit one-hot shift select. It drives the instantiated one-hot selector and returns the left-normalized mantissa, shift amount and tag through a two-stage valid/ready pipeline. It sits between the FADD close-path adder outputs and the rounding stage.

## Interface
- TAG_W, 8, width of the opaque per-request tag carried with the data
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset; synchronous, active-high
- flush  in  1  kill all in-flight operations (synchronous)
- req0_vld  in  1  requester 0 valid
- req0_data  in  54  requester 0 unnormalized mantissa
- req0_tag  in  TAG_W  requester 0 tag
- req0_rdy  out  1  requester 0 accepted this cycle when req0_vld & req0_rdy
- req1_vld, req1_data, req1_tag, req1_rdy: same as requester 0
- norm_vld  out  1  result valid
- norm_data  out  54  normalized mantissa (MSB = leading one)
- norm_shamt  out  6  left-shift amount, 0..53
- norm_zero  out  1  input mantissa was zero
- norm_src  out  1  requester index of this result
- norm_tag  out  TAG_W  tag of this result
- norm_rdy  in  1  downstream accepts when norm_vld & norm_rdy

## Operation
- Arbiter: round-robin with a 1-bit priority pointer `rr`.
  - Reset value of `rr` is 0 (req0 favored).
  - Both requesting: grant the `rr` side, then toggle `rr`.
  - Single request: grant it; `rr` is unchanged.
  - At most one grant per cycle. `reqX_rdy` = grant & s1_free & !flush.
- Stage 1 (s1) captures the granted data, tag and src, plus:
  - `onehot[53:0]`: only the highest set bit of the data.
  - `shamt` = 53 − index of that bit.
  - `zero` = (data == 0). When zero: onehot = 0 and shamt = 0.
- Stage 2 (s2):
  - Feeds s1 data/onehot to the selector sub-module.
  - Registers `result`, `shamt`, `zero`, `src` and `tag` into the output regs.
- Handshake:
  - s2 advance = s1_vld & (!s2_vld | norm_rdy).
  - s1_free = !s1_vld | s2 advance. Full-throughput when norm_rdy is held high.
  - Outputs hold stable while norm_vld & !norm_rdy.
- flush:
  - Clears s1_vld and s2_vld next cycle.
  - Blocks acceptance in the flush cycle.
  - Has priority over any simultaneous accept or advance.
- Reset: all valids 0, `rr` 0, and every data/tag/shamt/zero/src register 0. Hence norm_data = 0, norm_shamt = 0, norm_zero = 0, norm_src = 0, norm_tag = 0.
  - Reset mid-operation discards both stages.
  - reqX_rdy is low while cpurst is high.

## Timing
- Latency: accepted at edge N → norm_vld high in cycle N+2 (after edge N+1). Result is available at edge N+2.
- Throughput: one result per cycle with no backpressure.
- Backpressure:
  - With s2 stalled and s1 full, req rdy falls in the same cycle (combinational from norm_rdy).
  - No combinational path from reqX_data to outputs.
- Selector defined cases are one-hot or all-zero only; the controller never drives multi-hot.

## Structure
- Shared package (ct_fadd_pkg) holds:
  - MANT_W = 54, SHAMT_W = 6.
  - A leading-one-detect function returning onehot plus shamt.
- Sub-module: instantiate ct_fadd_onehot_sel_d as the shifter (data_in, onehot → result).
- The leading-one detector stays local (priority encoder). The arbiter is inline, a few lines.

## Test plan
- Single op: req0 data = 54'h00_0000_0000_0001, tag 0x5A.
  - Expect norm_data = 54'h20_0000_0000_0000, shamt 53, zero 0, src 0, tag 0x5A, exactly 2 cycles after accept.
- Zero input: req1 data = 0 → norm_data 0, zero 1, shamt 0, src 1.
- Contention: req0 and req1 held valid for 4 cycles, norm_rdy = 1.
  - Grants alternate 0,1,0,1 starting from reset pointer 0.
  - Results come back in the same order with their tags.
- Backpressure: stream 5 ops, norm_rdy low for 3 cycles mid-stream.
  - No result dropped or duplicated; outputs hold stable while stalled; req rdy drops when both stages are full.
- Flush: flush asserted with both stages valid and a new request pending.
  - Next cycle norm_vld = 0; the request is not accepted that cycle; it is accepted the following cycle.
- Reset mid-stream: assert cpurst for 1 cycle with both stages full.
  - All outputs 0; rr = 0 (req0 wins next contention).
